// File: rtl/seq_rem_pkg.sv
// Shared types and helpers for the sequential sign-magnitude remainder unit.
// Used by seq_signed_rem (optional quotient output: SEQ_REM_QUOT_EN).
package seq_rem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of magnitude bits in a sign-magnitude word of the given width.
    function automatic int mag_w(input int width);
        return width - 1;
    endfunction

    // Strip the sign bit of a sign-magnitude word held in the low width bits.
    function automatic logic [31:0] sm_mag(input logic [31:0] value, input int width);
        logic [31:0] mask;
        mask = (32'h1 << (width - 1)) - 32'h1;
        return value & mask;
    endfunction

endpackage

// File: rtl/seq_signed_rem_rem_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference only when it did not borrow.
module rem_step #(
    parameter int M = 3
) (
    input  logic [M:0]   prem_in,
    input  logic         dvd_bit,
    input  logic [M-1:0] divisor,
    output logic [M:0]   prem_out,
    output logic         q_bit
);

    logic [M:0]   trial;
    logic [M+1:0] diff;
    logic         unused_prem_msb;

    // The restored remainder is always below the divisor, so its top bit is zero.
    assign unused_prem_msb = prem_in[M];

    assign trial    = {prem_in[M-1:0], dvd_bit};
    assign diff     = {1'b0, trial} - {2'b00, divisor};
    assign q_bit    = ~diff[M+1];
    assign prem_out = q_bit ? diff[M:0] : trial;

endmodule

// File: rtl/seq_signed_rem.sv
// Multi-cycle sign-magnitude remainder (restoring, one bit per clock) with
// valid/ready handshakes. Define SEQ_REM_QUOT_EN to add the quot output.
module seq_signed_rem
    import seq_rem_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] rem,
    output logic             sf,
    output logic             zf,
    output logic             dzf
`ifdef SEQ_REM_QUOT_EN
    ,
    output logic [WIDTH-1:0] quot
`endif
);

    localparam int M  = mag_w(WIDTH);
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [M-1:0]  dvd;
    logic [M-1:0]  b_mag;
    logic [M:0]    prem;
    logic          sign_a;

    logic [M-1:0]  a_mag_in;
    logic [M-1:0]  b_mag_in;
    logic [M:0]    step_rem;
    logic          step_q;
    logic          rem_nz;

    assign a_mag_in = M'(sm_mag(32'(a), WIDTH));
    assign b_mag_in = M'(sm_mag(32'(b), WIDTH));
    assign rem_nz   = |step_rem[M-1:0];

    rem_step #(.M(M)) u_step (
        .prem_in  (prem),
        .dvd_bit  (dvd[M-1]),
        .divisor  (b_mag),
        .prem_out (step_rem),
        .q_bit    (step_q)
    );

`ifdef SEQ_REM_QUOT_EN
    logic          sign_b;
    logic [M-1:0]  quot_acc;
    logic [M-1:0]  quot_next;

    assign quot_next = {quot_acc[M-2:0], step_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_b   <= 1'b0;
            quot_acc <= '0;
            quot     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign_b   <= b[WIDTH-1];
                    quot_acc <= '0;
                    if (b_mag_in == '0)
                        quot <= '0;
                end
                CALC: begin
                    quot_acc <= quot_next;
                    if (cnt == '0)
                        quot <= {(sign_a ^ sign_b) & (|quot_next), quot_next};
                end
                default: ;
            endcase
        end
    end
`else
    logic unused_step_q;
    assign unused_step_q = step_q;
`endif

    // NOTE: all state here is written with <= so every register samples the
    // pre-edge values; mixing in = would make results depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            cnt       <= '0;
            dvd       <= '0;
            b_mag     <= '0;
            prem      <= '0;
            sign_a    <= 1'b0;
            rem       <= '0;
            sf        <= 1'b0;
            zf        <= 1'b0;
            dzf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_a   <= a[WIDTH-1];
                        dvd      <= a_mag_in;
                        b_mag    <= b_mag_in;
                        prem     <= '0;
                        cnt      <= CW'(M - 1);
                        in_ready <= 1'b0;
                        if (b_mag_in == '0) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                            rem       <= '0;
                            sf        <= a[WIDTH-1];
                            zf        <= 1'b1;
                            dzf       <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem <= step_rem;
                    dvd  <= dvd << 1;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        // Sign is suppressed on a zero remainder: no negative zero.
                        rem       <= {sign_a & rem_nz, step_rem[M-1:0]};
                        sf        <= sign_a;
                        zf        <= ~rem_nz;
                        dzf       <= 1'b0;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
